i2c_slave_regbank: RTL

- Synchronous, multi-address register memory behind the I2C slave control unit; successor to the single-address slave memory.
- Each matched slave address owns a bank of NBYTES registers.
- Adds a TMP10X-style pointer register with auto-increment/wrap, per-byte read-only protection, and a host-side update port for the sensor core.
- Sits between the I2C bit/byte engine (byte-level strobes) and the sensor datapath.

---
 rtl/i2c_regbank_pkg.sv | 26 ++
 rtl/i2c_addr_match.sv | 26 ++
 rtl/i2c_slave_regbank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_regbank_pkg.sv
// Shared definitions for the multi-address I2C slave register bank:
// transfer-phase encoding and constant helpers used to size pointers/indices.
package i2c_regbank_pkg;

  // Transfer phase of the slave after an address match
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no active transfer addressed to us
    ST_PTR   = 2'd1,  // write transfer, next byte is the register pointer
    ST_WRITE = 2'd2,  // write transfer, bytes go into the register bank
    ST_READ  = 2'd3   // read transfer, bytes come out of the register bank
  } state_t;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // Clamp a width to at least one bit
  function automatic int max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/i2c_addr_match.sv
// Combinational priority matcher: compares an incoming slave address against
// a list of addresses; the lowest matching index wins.
module i2c_addr_match #(
  parameter int ADDRESSLENGTH = 7,
  parameter int ADDRESSNUM    = 2,
  parameter int IDW           = 1
) (
  input  logic [ADDRESSLENGTH-1:0]            i_Address,
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] i_AddressList,
  output logic                                o_Hit,
  output logic [IDW-1:0]                      o_Index
);

  // Scan from the highest index down so the lowest match is the last one assigned
  always_comb begin
    o_Hit   = 1'b0;
    o_Index = '0;
    for (int i = ADDRESSNUM - 1; i >= 0; i--) begin
      if (i_Address == i_AddressList[i*ADDRESSLENGTH +: ADDRESSLENGTH]) begin
        o_Hit   = 1'b1;
        o_Index = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regbank.sv
// Multi-address I2C slave register memory. Each matched slave address owns a
// bank of NBYTES registers addressed through a per-bank auto-incrementing
// pointer. Supports per-byte read-only protection for I2C writes and a
// host-side write port for the sensor core.
module i2c_slave_regbank
  import i2c_regbank_pkg::*;
#(
  parameter int ADDRESSLENGTH = 7,
  parameter int ADDRESSNUM    = 2,
  parameter int NBYTES        = 4,
  localparam int PW           = max1(clog2(NBYTES)),
  localparam int IDW          = max1(clog2(ADDRESSNUM))
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset,
  input  logic                                i_AddrValid,
  input  logic [ADDRESSLENGTH-1:0]            i_DirectionBuffer,
  input  logic                                i_RorW,
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] i_AddressList,
  input  logic [ADDRESSNUM*NBYTES-1:0]        i_ReadOnlyMask,
  input  logic                                i_WrStrobe,
  input  logic [7:0]                          i_InputBuffer,
  input  logic                                i_RdReq,
  input  logic                                i_StopDetected,
  input  logic                                i_HostWrEn,
  input  logic [IDW+PW-1:0]                   i_HostWrAddr,
  input  logic [7:0]                          i_HostWrData,
  output logic                                o_AddressFound,
  output logic [IDW-1:0]                      o_AddressID,
  output logic [7:0]                          o_OutputBuffer,
  output logic                                o_RdValid,
  output logic                                o_WrIgnored,
  output logic [8*NBYTES*ADDRESSNUM-1:0]      o_Data
);

  localparam int NTOT = ADDRESSNUM * NBYTES;
  localparam int BW   = max1(clog2(NTOT));

  state_t           r_state;
  logic             r_found;
  logic [IDW-1:0]   r_id;
  logic [PW-1:0]    r_ptr [ADDRESSNUM];
  logic [7:0]       r_mem [NTOT];
  logic [7:0]       r_out;
  logic             r_rd_valid;
  logic             r_wr_ignored;

  logic             w_hit;
  logic [IDW-1:0]   w_hit_idx;
  logic [PW-1:0]    w_cur_ptr;
  logic [PW-1:0]    w_ptr_inc;
  logic [BW-1:0]    w_cur_idx;
  logic             w_quiet;
  logic             w_data_strobe;
  logic             w_ro;
  logic             w_i2c_we;
  logic [IDW-1:0]   w_host_bank;
  logic [PW-1:0]    w_host_byte;
  logic             w_host_ok;
  logic [BW-1:0]    w_host_idx;
  logic             w_ptr_in_range;

  i2c_addr_match #(
    .ADDRESSLENGTH (ADDRESSLENGTH),
    .ADDRESSNUM    (ADDRESSNUM),
    .IDW           (IDW)
  ) u_match (
    .i_Address     (i_DirectionBuffer),
    .i_AddressList (i_AddressList),
    .o_Hit         (w_hit),
    .o_Index       (w_hit_idx)
  );

  // Pointer of the currently addressed bank and its wrapped successor
  assign w_cur_ptr = r_ptr[r_id];
  assign w_ptr_inc = (w_cur_ptr == PW'(NBYTES - 1)) ? '0 : w_cur_ptr + 1'b1;
  assign w_cur_idx = BW'(r_id) * BW'(NBYTES) + BW'(w_cur_ptr);

  // Byte strobes only act when no START/STOP event preempts them this cycle
  assign w_quiet        = !i_AddrValid && !i_StopDetected;
  assign w_data_strobe  = w_quiet && i_WrStrobe && (r_state == ST_WRITE);
  assign w_ro           = i_ReadOnlyMask[w_cur_idx];
  assign w_i2c_we       = w_data_strobe && !w_ro;
  assign w_ptr_in_range = ({24'd0, i_InputBuffer} < 32'(NBYTES));

  // Host port decode; bank or byte indices beyond the configured size are dropped
  assign w_host_bank = i_HostWrAddr[IDW+PW-1:PW];
  assign w_host_byte = i_HostWrAddr[PW-1:0];
  assign w_host_ok   = i_HostWrEn && (32'(w_host_bank) < 32'(ADDRESSNUM))
                                  && (32'(w_host_byte) < 32'(NBYTES));
  assign w_host_idx  = BW'(w_host_bank) * BW'(NBYTES) + BW'(w_host_byte);

  // Register storage: the I2C write is issued last so it overrides a host write to the same byte
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < NTOT; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_host_ok) begin
        r_mem[w_host_idx] <= i_HostWrData;
      end
      if (w_i2c_we) begin
        r_mem[w_cur_idx] <= i_InputBuffer;
      end
    end
  end

  // Transfer FSM: address match, pointer load, pointer-driven write/read and pulse outputs
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= ST_IDLE;
      r_found      <= 1'b0;
      r_id         <= '0;
      r_out        <= '0;
      r_rd_valid   <= 1'b0;
      r_wr_ignored <= 1'b0;
      for (int i = 0; i < ADDRESSNUM; i++) begin
        r_ptr[i] <= '0;
      end
    end else begin
      r_rd_valid   <= 1'b0;
      r_wr_ignored <= 1'b0;
      if (i_AddrValid) begin
        // (Repeated) START is honoured in every state and beats a same-cycle STOP
        if (w_hit) begin
          r_found <= 1'b1;
          r_id    <= w_hit_idx;
          r_state <= i_RorW ? ST_PTR : ST_READ;
        end else begin
          r_found <= 1'b0;
          r_state <= ST_IDLE;
        end
      end else if (i_StopDetected) begin
        r_found <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_PTR: begin
            if (i_WrStrobe) begin
              if (w_ptr_in_range) begin
                r_ptr[r_id] <= i_InputBuffer[PW-1:0];
              end else begin
                r_ptr[r_id]  <= '0;
                r_wr_ignored <= 1'b1;
              end
              r_state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (i_WrStrobe) begin
              r_wr_ignored <= w_ro;
              r_ptr[r_id]  <= w_ptr_inc;
            end
          end
          ST_READ: begin
            if (i_RdReq) begin
              r_out       <= r_mem[w_cur_idx];
              r_rd_valid  <= 1'b1;
              r_ptr[r_id] <= w_ptr_inc;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Flatten the register array into the full image seen by the sensor datapath
  for (genvar gi = 0; gi < NTOT; gi++) begin : g_image
    assign o_Data[gi*8 +: 8] = r_mem[gi];
  end

  assign o_AddressFound = r_found;
  assign o_AddressID    = r_id;
  assign o_OutputBuffer = r_out;
  assign o_RdValid      = r_rd_valid;
  assign o_WrIgnored    = r_wr_ignored;

endmodule
